score_counter: RTL and testbench
================================

// Module: score_counter
// PURPOSE
//  Consumer end of the score tick from the clock divider: detects rising edges of the 9 Hz score_tick.
//  Accumulates a saturating BCD score while gameon; optionally tracks a high score.
//  Streams snapshot digits MSD-first over a valid/ready link to the OLED text renderer.
//  Sits between the score divider and the display path; one per design.
// PARAMETERS
//  NUM_DIGITS  4  BCD digits per score value (legal 2..6); score width SW = 4*NUM_DIGITS.
// PORTS
//  clk          in   1   system clock, 27 MHz.
//  rst_n        in   1   asynchronous active-low reset.
//  score_tick   in   1   toggling tick, synchronous to clk; each 0->1 edge = one point.
//  gameon       in   1   high while play state active; gates counting.
//  game_start   in   1   one-cycle pulse; clears current score.
//  frame_req    in   1   one-cycle pulse; snapshot score(s) and start digit stream.
//  score_bcd    out  SW  current score, BCD, digit NUM_DIGITS-1 in MSBs.
//  score_max    out  1   high while score_bcd == all 9s (saturated).
//  hiscore_bcd  out  SW  high score, BCD (0 when SCORE_HISCORE_EN undefined).
//  new_hiscore  out  1   one-cycle pulse when the high score is raised.
//  dig_valid    out  1   stream digit valid.
//  dig_ready    in   1   renderer accepts digit.
//  dig_data     out  4   BCD digit value 0..9.
//  dig_idx      out  3   digit position in stream, 0 = first sent.
//  dig_last     out  1   high with final digit of stream.
// BEHAVIOUR
//  Reset: all outputs 0, tick_q=0, hiscore=0, FSM IDLE. Async assert, sync-released by upstream.
//  Edge detect: rise = score_tick & ~tick_q; tick_q <= score_tick every cycle (no synchroniser; same clock).
//  Count: on rise & gameon & ~game_start, score += 1 in BCD (digit 9 -> 0 with carry to next digit).
//  Update latency: score_bcd reflects increment after the same edge that samples rise.
//  Saturation: at all 9s, further rises ignored; score_max=1; no wrap to 0.
//  Priority: game_start beats rise in same cycle -> score = 0, edge consumed (tick_q still updates).
//  Rise with gameon=0 is dropped, not deferred.
//  Digit stream FSM:
//    IDLE: frame_req -> capture snap, idx=0, dig_valid=1, go SEND.
//    SEND: on dig_valid & dig_ready, advance idx; on last digit accepted -> IDLE, dig_valid=0 next cycle.
//  Stream rules: frame_req in SEND ignored. dig_data/idx/last stable while valid & ~ready.
//  Stream content is the snapshot; score changes mid-stream do not affect it.
//  Stream length L = NUM_DIGITS (score only) or 2*NUM_DIGITS (score then hiscore).
//  dig_last = (idx == L-1) & dig_valid.
//  Reset mid-stream: dig_valid drops immediately, FSM to IDLE.
// CONFIGURATION
//  SCORE_HISCORE_EN defined: hiscore register tracks the max score.
//    When incremented score > hiscore, hiscore <= new score same edge and new_hiscore pulses.
//    hiscore survives game_start; cleared only by rst_n. Stream sends score digits then hiscore digits.
//  SCORE_HISCORE_EN undefined: no hiscore register; hiscore_bcd=0, new_hiscore=0, L=NUM_DIGITS.
// STRUCTURE
//  Package score_pkg: BCD_W=4, BCD_MAX=4'd9, stream FSM state enum (ST_IDLE, ST_SEND),
//    DIG_IDX_W=3, function bcd_gt(a,b) for hiscore compare.
//  Sub-module bcd_digit: one digit with inc_in, clr, sat, carry_out; instantiated NUM_DIGITS times via generate.
//  Top holds edge detect, saturation, hiscore, snapshot and stream FSM.
// TESTING
//  1. Reset, gameon=1, 12 score_tick toggles (6 rises) -> score_bcd=16'h0006, score_max=0.
//  2. Preload to 0x0099 via rises; one more rise -> 0x0100; at 0x9999 further rises -> stays 0x9999, score_max=1.
//  3. game_start same cycle as rise at score 0x0042 -> 0x0000; next rise -> 0x0001.
//  4. gameon=0, 5 rises -> score unchanged; gameon=1 with tick already high -> no count until next 0->1.
//  5. Score 0x1234, frame_req, dig_ready held low 3 cycles then high -> digits 1,2,3,4 with idx 0..3.
//     Data stable during stall; dig_last on digit 4; frame_req mid-stream ignored.
//  6. SCORE_HISCORE_EN: play to 0x0007, game_start, play to 0x0003 -> hiscore 0x0007.
//     Stream = 0,0,0,3,0,0,0,7; reach 0x0008 -> new_hiscore one-cycle pulse.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and helpers for the score counter: BCD constants, stream FSM states, BCD compare.
// No logic of its own; imported by bcd_digit and score_counter.
package score_pkg;

    localparam int          BCD_W     = 4;
    localparam logic [3:0]  BCD_MAX   = 4'd9;
    localparam int          DIG_IDX_W = 3;
    localparam int          MAX_SW    = 24;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } st_e;

    // Packed BCD keeps numeric ordering, so a plain binary compare is exact.
    function automatic logic bcd_gt(input logic [MAX_SW-1:0] a, input logic [MAX_SW-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: counts 0..9 on inc_in, clears on clr, holds while sat.
// Latency: value updates on the edge that samples inc_in; carry_out is combinational.
// Backpressure: none; sat freezes the digit instead of wrapping.
module bcd_digit
    import score_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_in,
    input  logic             clr,
    input  logic             sat,
    output logic [BCD_W-1:0] dig,
    output logic             carry_out
);

    logic [BCD_W-1:0] dig_q;
    logic [BCD_W-1:0] dig_d;

    always_comb begin
        dig_d = dig_q;
        if (clr) begin
            dig_d = '0;
        end else if (inc_in && !sat) begin
            dig_d = (dig_q == BCD_MAX) ? '0 : dig_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dig_q <= '0;
        else        dig_q <= dig_d;
    end

    assign dig       = dig_q;
    assign carry_out = inc_in & (dig_q == BCD_MAX);

endmodule

// File: rtl/score_counter.sv
// Score accumulator: tick edge detect, saturating BCD count, optional high score (SCORE_HISCORE_EN), MSD-first digit stream.
// Latency: score updates on the edge sampling the tick rise; stream starts the cycle after frame_req.
// Backpressure: dig_ready low holds the current digit; frame_req while streaming is ignored.
module score_counter
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      score_tick,
    input  logic                      gameon,
    input  logic                      game_start,
    input  logic                      frame_req,
    output logic [4*NUM_DIGITS-1:0]   score_bcd,
    output logic                      score_max,
    output logic [4*NUM_DIGITS-1:0]   hiscore_bcd,
    output logic                      new_hiscore,
    output logic                      dig_valid,
    input  logic                      dig_ready,
    output logic [BCD_W-1:0]          dig_data,
    output logic [DIG_IDX_W-1:0]      dig_idx,
    output logic                      dig_last
);

    localparam int SW = BCD_W * NUM_DIGITS;
`ifdef SCORE_HISCORE_EN
    localparam int L = 2 * NUM_DIGITS;
`else
    localparam int L = NUM_DIGITS;
`endif
    localparam int SNAP_W = L * BCD_W;
    // One extra index bit so a 12-digit stream still finds its last digit.
    localparam int IDX_CW = DIG_IDX_W + 1;

    logic tick_q;
    logic tick_d;
    logic inc_req;
    logic [NUM_DIGITS:0] carry;

    assign tick_d   = score_tick;
    assign inc_req  = score_tick & ~tick_q & gameon & ~game_start;
    assign carry[0] = inc_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_q <= 1'b0;
        else        tick_q <= tick_d;
    end

    // carry out of the MSD means the increment would wrap: freeze every digit.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        bcd_digit u_dig (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc_in    (carry[g]),
            .clr       (game_start),
            .sat       (carry[NUM_DIGITS]),
            .dig       (score_bcd[g*BCD_W +: BCD_W]),
            .carry_out (carry[g+1])
        );
    end

    always_comb begin
        score_max = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (score_bcd[i*BCD_W +: BCD_W] != BCD_MAX) score_max = 1'b0;
        end
    end

    logic [SNAP_W-1:0] snap_cap;

`ifdef SCORE_HISCORE_EN
    logic [SW-1:0] hiscore_q;
    logic [SW-1:0] hiscore_d;
    logic          new_hiscore_q;
    logic          new_hiscore_d;
    logic [SW-1:0] score_nxt;

    always_comb begin
        score_nxt = score_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry[i]) begin
                score_nxt[i*BCD_W +: BCD_W] = (score_bcd[i*BCD_W +: BCD_W] == BCD_MAX) ?
                                              '0 : score_bcd[i*BCD_W +: BCD_W] + 4'd1;
            end
        end
        hiscore_d     = hiscore_q;
        new_hiscore_d = 1'b0;
        if (inc_req && !carry[NUM_DIGITS] &&
            bcd_gt(MAX_SW'(score_nxt), MAX_SW'(hiscore_q))) begin
            hiscore_d     = score_nxt;
            new_hiscore_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hiscore_q     <= '0;
            new_hiscore_q <= 1'b0;
        end else begin
            hiscore_q     <= hiscore_d;
            new_hiscore_q <= new_hiscore_d;
        end
    end

    assign hiscore_bcd = hiscore_q;
    assign new_hiscore = new_hiscore_q;
    assign snap_cap    = {score_bcd, hiscore_q};
`else
    assign hiscore_bcd = '0;
    assign new_hiscore = 1'b0;
    assign snap_cap    = score_bcd;
`endif

    st_e               state_q, state_d;
    logic [IDX_CW-1:0] idx_q, idx_d;
    logic [SNAP_W-1:0] snap_q, snap_d;
    logic              is_last;

    assign is_last = (idx_q == IDX_CW'(L - 1));

    // Snapshot is a shift register: the digit on the wire is always its top nibble.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_req) begin
                    snap_d  = snap_cap;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (dig_ready) begin
                    snap_d = snap_q << BCD_W;
                    if (is_last) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    assign dig_valid = (state_q == ST_SEND);
    assign dig_data  = snap_q[SNAP_W-1 -: BCD_W];
    assign dig_idx   = idx_q[DIG_IDX_W-1:0];
    assign dig_last  = dig_valid & is_last;

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter (NUM_DIGITS=4); high-score steps build only with SCORE_HISCORE_EN.
module tb_score_counter;

    logic        clk = 1'b0;
    logic        rst_n, score_tick, gameon, game_start, frame_req, dig_ready;
    logic [15:0] score_bcd, hiscore_bcd;
    logic        score_max, new_hiscore, dig_valid, dig_last;
    logic [3:0]  dig_data;
    logic [2:0]  dig_idx;

    int vectors     = 0;
    int miscompares = 0;

`ifdef SCORE_HISCORE_EN
    localparam int L = 8;
`else
    localparam int L = 4;
`endif

    always #5 clk = ~clk;

    score_counter #(.NUM_DIGITS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .score_tick  (score_tick),
        .gameon      (gameon),
        .game_start  (game_start),
        .frame_req   (frame_req),
        .score_bcd   (score_bcd),
        .score_max   (score_max),
        .hiscore_bcd (hiscore_bcd),
        .new_hiscore (new_hiscore),
        .dig_valid   (dig_valid),
        .dig_ready   (dig_ready),
        .dig_data    (dig_data),
        .dig_idx     (dig_idx),
        .dig_last    (dig_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rises(input int n);
        for (int i = 0; i < n; i++) begin
            score_tick = 1'b1;
            step();
            score_tick = 1'b0;
            step();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        game_start = 1'b1;
        step();
        game_start = 1'b0;
    endtask

    // Streams the current snapshot with dig_ready already high; snap holds L digits in its low nibbles.
    task automatic chk_stream(input string tag, input logic [31:0] snap);
        logic [3:0] exp_dig;
        for (int k = 0; k < L; k++) begin
            exp_dig = snap[(L-1-k)*4 +: 4];
            chk({tag, "_valid"}, 32'(dig_valid), 32'd1);
            chk({tag, "_data"},  32'(dig_data),  32'(exp_dig));
            chk({tag, "_idx"},   32'(dig_idx),   32'(k));
            chk({tag, "_last"},  32'(dig_last),  32'(k == L-1));
            step();
        end
        chk({tag, "_done"}, 32'(dig_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_snap;
        rst_n = 1'b0; score_tick = 1'b0; gameon = 1'b0; game_start = 1'b0;
        frame_req = 1'b0; dig_ready = 1'b0;
        repeat (3) step();
        chk("rst_score",   32'(score_bcd),   32'h0);
        chk("rst_max",     32'(score_max),   32'h0);
        chk("rst_valid",   32'(dig_valid),   32'h0);
        chk("rst_hiscore", 32'(hiscore_bcd), 32'h0);
        chk("rst_newhi",   32'(new_hiscore), 32'h0);
        rst_n = 1'b1;
        step();

        // Six rises
        gameon = 1'b1;
        rises(6);
        chk("six_rises", 32'(score_bcd), 32'h0006);
        chk("six_max",   32'(score_max), 32'h0);

        // Carry chain and saturation
        pulse_start();
        rises(99);
        chk("to_0099", 32'(score_bcd), 32'h0099);
        rises(1);
        chk("to_0100", 32'(score_bcd), 32'h0100);
        rises(9899);
        chk("to_9999", 32'(score_bcd), 32'h9999);
        chk("max_set", 32'(score_max), 32'h1);
        rises(2);
        chk("sat_hold",     32'(score_bcd), 32'h9999);
        chk("sat_max_hold", 32'(score_max), 32'h1);

        // game_start beats a simultaneous rise
        pulse_start();
        chk("start_clr", 32'(score_bcd), 32'h0);
        rises(42);
        chk("to_0042", 32'(score_bcd), 32'h0042);
        score_tick = 1'b1; game_start = 1'b1;
        step();
        score_tick = 1'b0; game_start = 1'b0;
        step();
        chk("start_vs_rise", 32'(score_bcd), 32'h0000);
        rises(1);
        chk("after_start", 32'(score_bcd), 32'h0001);

        // gameon gating; rise while gameon=0 is dropped
        gameon = 1'b0;
        rises(5);
        chk("gameon_off", 32'(score_bcd), 32'h0001);
        score_tick = 1'b1;
        step();
        step();
        gameon = 1'b1;
        step();
        step();
        chk("tick_held_high", 32'(score_bcd), 32'h0001);
        score_tick = 1'b0;
        step();
        score_tick = 1'b1;
        step();
        chk("next_edge_counts", 32'(score_bcd), 32'h0002);
        score_tick = 1'b0;
        step();

        // Stream with stall, mid-stream score change and ignored frame_req
        pulse_start();
        rises(1234);
        chk("to_1234", 32'(score_bcd), 32'h1234);
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        chk("st_first_valid", 32'(dig_valid), 32'h1);
        score_tick = 1'b1;
        step();
        chk("stall1_data", 32'(dig_data), 32'h1);
        score_tick = 1'b0;
        frame_req  = 1'b1;
        step();
        frame_req = 1'b0;
        chk("stall2_data", 32'(dig_data), 32'h1);
        chk("stall2_idx",  32'(dig_idx),  32'h0);
        step();
        chk("stall3_data", 32'(dig_data), 32'h1);
        chk("stall3_last", 32'(dig_last), 32'h0);
        dig_ready = 1'b1;
`ifdef SCORE_HISCORE_EN
        exp_snap = 32'h1234_9999;
`else
        exp_snap = 32'h0000_1234;
`endif
        chk_stream("s1234", exp_snap);
        chk("score_moved_on", 32'(score_bcd), 32'h1235);
        dig_ready = 1'b0;
        step();

        // Asynchronous reset in the middle of a stream
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        step();
        chk("pre_rst_valid", 32'(dig_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(dig_valid), 32'h0);
        chk("async_rst_score", 32'(score_bcd), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", 32'(dig_valid), 32'h0);

`ifdef SCORE_HISCORE_EN
        gameon = 1'b1;
        rises(7);
        chk("hi_to_7", 32'(hiscore_bcd), 32'h0007);
        pulse_start();
        rises(3);
        chk("hi_score_3", 32'(score_bcd),   32'h0003);
        chk("hi_kept_7",  32'(hiscore_bcd), 32'h0007);
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        dig_ready = 1'b1;
        chk_stream("s_hi", 32'h0003_0007);
        dig_ready = 1'b0;
        rises(4);
        chk("hi_no_pulse_at_7", 32'(new_hiscore), 32'h0);
        score_tick = 1'b1;
        step();
        chk("hi_pulse",  32'(new_hiscore), 32'h1);
        chk("hi_raised", 32'(hiscore_bcd), 32'h0008);
        score_tick = 1'b0;
        step();
        chk("hi_pulse_end", 32'(new_hiscore), 32'h0);
`else
        rises(3);
        chk("nohi_zero",  32'(hiscore_bcd), 32'h0);
        chk("nohi_pulse", 32'(new_hiscore), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
